// File: rtl/bsg_wormhole_concentrator_sched_if.sv
// bsg_wormhole_concentrator_sched_if: bundle between the input FIFO heads, the
// concentrated link and the packet scheduler.
//   v         per-input FIFO-head valid
//   len       per-input header length field (body flits after the header)
//   weights   per-input weight; input i may send weights[i]+1 packets per turn
//   ready_and downstream ready on the concentrated link
//   link_v    concentrated link valid
//   data_sel  one-hot mux select toward the concentrator data path
//   yumi      per-input dequeue, at most one bit set
//   locked    a packet is in progress
interface bsg_wormhole_concentrator_sched_if #(
    parameter int num_in_p       = 4,
    parameter int len_width_p    = 4,
    parameter int weight_width_p = 2
);
    logic [num_in_p-1:0]                v;
    logic [num_in_p*len_width_p-1:0]    len;
    logic [num_in_p*weight_width_p-1:0] weights;
    logic                               ready_and;
    logic                               link_v;
    logic [num_in_p-1:0]                data_sel;
    logic [num_in_p-1:0]                yumi;
    logic                               locked;

    modport master (
        output v, len, weights, ready_and,
        input  link_v, data_sel, yumi, locked
    );

    modport slave (
        input  v, len, weights, ready_and,
        output link_v, data_sel, yumi, locked
    );
endinterface

// File: rtl/bsg_wormhole_concentrator_sched.sv
// bsg_wormhole_concentrator_sched: weighted round-robin packet scheduler that
// locks one concentrated wormhole link to a single input for a whole packet.
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   bus        slave side of the scheduler interface (FIFO heads in,
//              link valid / mux select / dequeues / locked out)
module bsg_wormhole_concentrator_sched #(
    parameter int num_in_p       = 4,
    parameter int len_width_p    = 4,
    parameter int weight_width_p = 2
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_wormhole_concentrator_sched_if.slave bus
);
    localparam int PW = num_in_p > 1 ? $clog2(num_in_p) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                    state_r, state_n;
    logic [num_in_p-1:0]       owner_r, owner_n;
    logic [len_width_p-1:0]    remain_r, remain_n;
    logic [weight_width_p-1:0] burst_r, burst_n;
    logic [PW-1:0]             ptr_r, ptr_n;

    logic [num_in_p-1:0]       rr_win, win, sel;
    logic                      found, cont, forfeit, offer, xfer, tail;
    logic [len_width_p-1:0]    sel_len;
    logic [weight_width_p-1:0] sel_w, base_b;
    logic [PW-1:0]             sel_nptr, own_nptr, base_p;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            owner_r  <= '0;
            remain_r <= '0;
            burst_r  <= '0;
            ptr_r    <= '0;
        end else begin
            state_r  <= state_n;
            owner_r  <= owner_n;
            remain_r <= remain_n;
            burst_r  <= burst_n;
            ptr_r    <= ptr_n;
        end
    end

    always_comb begin
        rr_win = '0;
        found  = 1'b0;
        // first valid input at or after the pointer, wrapping around
        for (int k = 0; k < num_in_p; k++)
            for (int i = 0; i < num_in_p; i++)
                if (!found && bus.v[i] && i == (int'(ptr_r) + k) % num_in_p) begin
                    rr_win[i] = 1'b1;
                    found     = 1'b1;
                end
        cont    = burst_r != '0 && |(bus.v & owner_r);
        // owner still has burst credit but is idle: credit is lost only if someone else transfers
        forfeit = state_r == IDLE && burst_r != '0 && !cont;
        win     = cont ? owner_r : rr_win;
        sel     = state_r == BUSY ? owner_r : win;
        offer   = state_r == BUSY ? |(bus.v & owner_r) : |bus.v;
        xfer    = offer && bus.ready_and;
        sel_len  = '0;
        sel_w    = '0;
        sel_nptr = '0;
        own_nptr = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (sel[i]) begin
                sel_len  = bus.len[i*len_width_p +: len_width_p];
                sel_w    = bus.weights[i*weight_width_p +: weight_width_p];
                sel_nptr = i == num_in_p - 1 ? '0 : PW'(i + 1);
            end
            if (owner_r[i])
                own_nptr = i == num_in_p - 1 ? '0 : PW'(i + 1);
        end
        tail   = state_r == BUSY ? remain_r == len_width_p'(1) : sel_len == '0;
        base_b = forfeit ? '0 : burst_r;
        base_p = forfeit ? own_nptr : ptr_r;
        state_n  = state_r;
        owner_n  = owner_r;
        remain_n = remain_r;
        burst_n  = burst_r;
        ptr_n    = ptr_r;
        if (xfer) begin
            owner_n = sel;
            burst_n = base_b;
            ptr_n   = base_p;
            if (state_r == BUSY) begin
                remain_n = remain_r - len_width_p'(1);
                state_n  = tail ? IDLE : BUSY;
            end else if (!tail) begin
                remain_n = sel_len;
                state_n  = BUSY;
            end
            if (tail) begin
                burst_n = base_b < sel_w ? base_b + weight_width_p'(1) : '0;
                ptr_n   = base_b < sel_w ? base_p : sel_nptr;
            end
        end
    end

    assign bus.link_v   = reset_n_i && offer;
    assign bus.data_sel = reset_n_i ? sel : '0;
    assign bus.yumi     = reset_n_i ? sel & bus.v & {num_in_p{bus.ready_and}} : '0;
    assign bus.locked   = reset_n_i && state_r == BUSY;
endmodule
